// File: rtl/func_sel_sync_mux_if.sv
// rtl/func_sel_sync_mux_if.sv - write/readback bus of the DO function mux
//   wr_en      master->slave  one-cycle write strobe
//   wr_ch      master->slave  channel addressed by the write
//   wr_func    master->slave  new function code
//   wr_level   master->slave  new level bit (used by code 0)
//   rd_ch      master->slave  readback channel select
//   rd_func    slave->master  active function of rd_ch
//   rd_pending slave->master  rd_ch has a pending change
interface func_sel_sync_mux_if #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [SEL_W-1:0] wr_func;
  logic             wr_level;
  logic [CH_W-1:0]  rd_ch;
  logic [SEL_W-1:0] rd_func;
  logic             rd_pending;

  modport master (
    output wr_en, wr_ch, wr_func, wr_level, rd_ch,
    input  rd_func, rd_pending
  );

  modport slave (
    input  wr_en, wr_ch, wr_func, wr_level, rd_ch,
    output rd_func, rd_pending
  );
endinterface

// File: rtl/func_sel_sync_mux.sv
// rtl/func_sel_sync_mux.sv - clocked glitch-free per-channel function mux for digital outputs
//   xclk                 in   system clock, rising edge
//   reset                in   synchronous, active-high
//   bus                  slave  write port (wr_*) and readback port (rd_*)
//   function_signals_in  in   N_SRC async function sources
//   selected_out         out  N_CH registered channel outputs
//   switch_pending       out  N_CH per-channel pending flag
module func_sel_sync_mux #(
  parameter int N_CH           = 4,
  parameter int N_SRC          = 10,
  parameter int SEL_W          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SWITCH_TIMEOUT = 255
) (
  input  logic                xclk,
  input  logic                reset,
  func_sel_sync_mux_if.slave  bus,
  input  logic [N_SRC-1:0]    function_signals_in,
  output logic [N_CH-1:0]     selected_out,
  output logic [N_CH-1:0]     switch_pending
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(SWITCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWITCH_TIMEOUT - 1);

  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t           state_q   [N_CH];
  state_t           state_d   [N_CH];
  logic [SEL_W-1:0] active_q  [N_CH];
  logic [SEL_W-1:0] active_d  [N_CH];
  logic [SEL_W-1:0] pending_q [N_CH];
  logic [SEL_W-1:0] pending_d [N_CH];
  logic [CNT_W-1:0] cnt_q     [N_CH];
  logic [CNT_W-1:0] cnt_d     [N_CH];
  logic [N_CH-1:0]  level_q;
  logic [N_CH-1:0]  level_d;
  logic [N_CH-1:0]  out_d;
  logic [N_CH-1:0]  wr_hit;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sig_s;

  assign sig_s = sync_q[SYNC_STAGES-1];

  // code 0 = level bit, 1..N_SRC = synchronised source, anything above drives 0
  function automatic logic sel_src(input logic [SEL_W-1:0] code,
                                   input logic             lvl,
                                   input logic [N_SRC-1:0] sig);
    logic r;
    r = 1'b0;
    if (code == '0) begin
      r = lvl;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (int'(code) == i + 1) r = sig[i];
      end
    end
    return r;
  endfunction

  // Out-of-range wr_ch never matches any channel index, so such writes fall away.
  always_comb begin
    wr_hit = '0;
    for (int c = 0; c < N_CH; c++) begin
      wr_hit[c] = bus.wr_en && ({1'b0, bus.wr_ch} == (CH_W + 1)'(c));
    end
  end

  always_comb begin
    level_d = level_q;
    out_d   = '0;
    for (int c = 0; c < N_CH; c++) begin
      state_d[c]   = state_q[c];
      active_d[c]  = active_q[c];
      pending_d[c] = pending_q[c];
      cnt_d[c]     = cnt_q[c];
      out_d[c]     = sel_src(active_q[c], level_q[c], sig_s);

      if (wr_hit[c]) begin
        // a write always wins over a same-cycle match or timeout
        level_d[c] = bus.wr_level;
        if (bus.wr_func == active_q[c]) begin
          state_d[c] = ST_ACTIVE;
        end else begin
          pending_d[c] = bus.wr_func;
          state_d[c]   = ST_PENDING;
          cnt_d[c]     = '0;
        end
      end else if (state_q[c] == ST_PENDING) begin
        // switch only when the new source already equals what the pad shows,
        // unless the wait has run out
        if ((sel_src(pending_q[c], level_q[c], sig_s) == selected_out[c]) ||
            (cnt_q[c] == CNT_LAST)) begin
          active_d[c] = pending_q[c];
          state_d[c]  = ST_ACTIVE;
          cnt_d[c]    = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge xclk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int c = 0; c < N_CH; c++) begin
        state_q[c]   <= ST_ACTIVE;
        active_q[c]  <= '0;
        pending_q[c] <= '0;
        cnt_q[c]     <= '0;
      end
      level_q      <= '0;
      selected_out <= '0;
    end else begin
      sync_q[0] <= function_signals_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int c = 0; c < N_CH; c++) begin
        state_q[c]   <= state_d[c];
        active_q[c]  <= active_d[c];
        pending_q[c] <= pending_d[c];
        cnt_q[c]     <= cnt_d[c];
      end
      level_q      <= level_d;
      selected_out <= out_d;
    end
  end

  always_comb begin
    switch_pending = '0;
    for (int c = 0; c < N_CH; c++) begin
      switch_pending[c] = (state_q[c] == ST_PENDING);
    end
  end

  always_comb begin
    bus.rd_func    = '0;
    bus.rd_pending = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if ({1'b0, bus.rd_ch} == (CH_W + 1)'(c)) begin
        bus.rd_func    = active_q[c];
        bus.rd_pending = (state_q[c] == ST_PENDING);
      end
    end
  end

endmodule

// File: tb/tb_func_sel_sync_mux.sv
// tb/tb_func_sel_sync_mux.sv - self-checking bench for func_sel_sync_mux against a behavioural model
module tb_func_sel_sync_mux;

  localparam int N_CH    = 4;
  localparam int N_SRC   = 10;
  localparam int SEL_W   = 4;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 255;

  logic             xclk;
  logic             reset;
  logic [N_SRC-1:0] src;
  logic [N_CH-1:0]  selected_out;
  logic [N_CH-1:0]  switch_pending;
  logic [2:0]       out3;
  logic [2:0]       pend3;

  func_sel_sync_mux_if #(.N_CH(N_CH), .SEL_W(SEL_W)) bus ();
  func_sel_sync_mux_if #(.N_CH(3), .SEL_W(SEL_W)) bus3 ();

  func_sel_sync_mux #(
    .N_CH(N_CH), .N_SRC(N_SRC), .SEL_W(SEL_W), .SYNC_STAGES(SYNC), .SWITCH_TIMEOUT(TIMEOUT)
  ) u_dut (
    .xclk(xclk), .reset(reset), .bus(bus), .function_signals_in(src),
    .selected_out(selected_out), .switch_pending(switch_pending)
  );

  // three-channel copy, so that wr_ch/rd_ch = N_CH is representable
  func_sel_sync_mux #(
    .N_CH(3), .N_SRC(N_SRC), .SEL_W(SEL_W), .SYNC_STAGES(SYNC), .SWITCH_TIMEOUT(TIMEOUT)
  ) u_dut3 (
    .xclk(xclk), .reset(reset), .bus(bus3), .function_signals_in(src),
    .selected_out(out3), .switch_pending(pend3)
  );

  initial xclk = 1'b0;
  always #5 xclk = ~xclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: per-channel view of the rules, source delay as a history of driven values
  int unsigned      m_active [N_CH];
  int unsigned      m_pcode  [N_CH];
  int unsigned      m_wait   [N_CH];
  bit               m_pend   [N_CH];
  bit               m_lvl    [N_CH];
  bit               m_out    [N_CH];
  logic [N_SRC-1:0] hist[$];

  function automatic bit m_sel(int unsigned code, bit lvl, logic [N_SRC-1:0] s);
    if (code == 0) return lvl;
    if (code <= N_SRC) return s[code-1];
    return 1'b0;
  endfunction

  task automatic model_clock();
    logic [N_SRC-1:0] s;
    bit nxt_out [N_CH];
    s = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : '0;
    for (int c = 0; c < N_CH; c++) nxt_out[c] = m_sel(m_active[c], m_lvl[c], s);
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        m_active[c] = 0; m_pcode[c] = 0; m_wait[c] = 0;
        m_pend[c] = 0; m_lvl[c] = 0; m_out[c] = 0;
      end
      hist.delete();
      return;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (bus.wr_en && int'(bus.wr_ch) == c) begin
        m_lvl[c] = bus.wr_level;
        if (int'(bus.wr_func) == m_active[c]) m_pend[c] = 0;
        else begin m_pend[c] = 1; m_pcode[c] = bus.wr_func; m_wait[c] = 0; end
      end else if (m_pend[c]) begin
        if (m_sel(m_pcode[c], m_lvl[c], s) == m_out[c] || m_wait[c] == TIMEOUT - 1) begin
          m_active[c] = m_pcode[c]; m_pend[c] = 0; m_wait[c] = 0;
        end else m_wait[c]++;
      end
    end
    for (int c = 0; c < N_CH; c++) m_out[c] = nxt_out[c];
    hist.push_back(src);
    while (hist.size() > SYNC) void'(hist.pop_front());
  endtask

  task automatic compare_all();
    logic [N_CH-1:0] eo, ep;
    for (int c = 0; c < N_CH; c++) begin eo[c] = m_out[c]; ep[c] = m_pend[c]; end
    check("selected_out", selected_out, eo);
    check("switch_pending", switch_pending, ep);
    check("rd_func", bus.rd_func, m_active[bus.rd_ch]);
    check("rd_pending", bus.rd_pending, m_pend[bus.rd_ch]);
  endtask

  task automatic tick();
    model_clock();
    @(posedge xclk);
    @(negedge xclk);
    compare_all();
    bus.wr_en  = 1'b0;
    bus3.wr_en = 1'b0;
  endtask

  task automatic wr(input int ch, input int func, input bit lvl);
    bus.wr_en = 1'b1; bus.wr_ch = ch[1:0]; bus.wr_func = func[SEL_W-1:0]; bus.wr_level = lvl;
    tick();
  endtask

  initial begin
    int pend_cycles;
    int first_hi;
    reset = 1'b1; src = 10'h3FF;
    bus.wr_en = 0; bus.wr_ch = 0; bus.wr_func = 0; bus.wr_level = 0; bus.rd_ch = 0;
    bus3.wr_en = 0; bus3.wr_ch = 0; bus3.wr_func = 0; bus3.wr_level = 0; bus3.rd_ch = 0;
    @(negedge xclk);

    // 1: reset, sources all high
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("t1_out", selected_out, 0);
    check("t1_pend", switch_pending, 0);
    for (int i = 0; i < N_CH; i++) begin
      bus.rd_ch = i[1:0]; #1;
      check("t1_rd_func", bus.rd_func, 0);
    end

    // 2: forced switch after the full timeout
    wr(0, 1, 0);
    pend_cycles = 0; first_hi = -1;
    for (int k = 0; k <= 260; k++) begin
      if (switch_pending[0]) pend_cycles++;
      if (selected_out[0] && first_hi < 0) first_hi = k;
      tick();
    end
    check("t2_pending_len", pend_cycles, 255);
    check("t2_out_cycle", first_hi, 256);

    // 3: matching sources switch in one cycle without an output glitch
    bus.rd_ch = 1;
    wr(1, 0, 1); repeat (3) tick();
    wr(1, 4, 1); repeat (3) tick();
    check("t3_code4", bus.rd_func, 4);
    wr(1, 10, 1);
    check("t3_pending", switch_pending[1], 1);
    tick();
    check("t3_switched", switch_pending[1], 0);
    check("t3_rd_func", bus.rd_func, 10);
    for (int k = 0; k < 3; k++) begin
      check("t3_no_glitch", selected_out[1], 1);
      tick();
    end

    // 4: source to output latency
    wr(2, 0, 1); repeat (3) tick();
    wr(2, 3, 1); repeat (3) tick();
    src[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t4_latency", selected_out[2], (k >= 3) ? 0 : 1);
    end

    // 5: rewrite restarts the wait, rewrite of the active code cancels
    bus.rd_ch = 3;
    wr(3, 5, 0);
    repeat (99) tick();
    wr(3, 7, 0);
    repeat (200) tick();
    check("t5_restart", switch_pending[3], 1);
    wr(3, 0, 0);
    check("t5_cancel", switch_pending[3], 0);
    check("t5_rd_func", bus.rd_func, 0);

    // 6: out-of-range channel, unused code, reset while pending
    bus3.wr_en = 1; bus3.wr_ch = 2'd3; bus3.wr_func = 4'd5; bus3.wr_level = 1;
    tick(); tick(); tick();
    check("t6_ign_out", out3, 0);
    check("t6_ign_pend", pend3, 0);
    bus3.wr_en = 1; bus3.wr_ch = 2'd0; bus3.wr_func = 4'd12; bus3.wr_level = 0;
    tick(); tick();
    bus3.rd_ch = 0; #1;
    check("t6_u3_rd0", bus3.rd_func, 12);
    bus3.rd_ch = 3; #1;
    check("t6_u3_rd_oor", bus3.rd_func, 0);
    check("t6_u3_rdp_oor", bus3.rd_pending, 0);
    bus3.wr_en = 1; bus3.wr_ch = 2'd2; bus3.wr_func = 4'd0; bus3.wr_level = 1;
    tick(); tick();
    check("t6_u3_valid", out3, 3'b100);

    wr(2, 12, 0); repeat (2) tick();
    src[2] = 1'b1;
    repeat (4) tick();
    check("t6_code12", selected_out[2], 0);
    wr(0, 0, 0); repeat (5) tick();
    check("t6_pre_rst", switch_pending[0], 1);
    reset = 1'b1;
    bus.wr_en = 1; bus.wr_ch = 1; bus.wr_func = 5; bus.wr_level = 1;
    tick();
    reset = 1'b0;
    check("t6_rst_out", selected_out, 0);
    check("t6_rst_pend", switch_pending, 0);
    bus.rd_ch = 1; #1;
    check("t6_rst_rd", bus.rd_func, 0);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 15) == 0) src = N_SRC'($urandom);
      bus.rd_ch = 2'($urandom_range(0, N_CH - 1));
      if ($urandom_range(0, 3) == 0) begin
        bus.wr_en = 1; bus.wr_ch = 2'($urandom_range(0, N_CH - 1));
        bus.wr_func = 4'($urandom_range(0, 15)); bus.wr_level = 1'($urandom);
      end
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
